// File: rtl/dsp_w_order_ctrl_if.sv
// rtl/dsp_w_order_ctrl_if.sv - handshake bundle between the AW/W dispatchers and the write-order controller
//
// Purpose: carries the AW/W handshake observations into the write-order
// controller and its steering/back-pressure outputs back to the dispatchers.
// Ports (signals):
//   m_AWVALID_i, m_AWREADY_i, m_AW_slv_id_i : AW handshake and decoded slave ID
//   m_WVALID_i, m_WREADY_i, m_WLAST_i       : W handshake and burst end
//   dsp_AW_slv_id_o, dsp_AW_disable_o       : W dispatcher steering
//   dsp_AW_stall_o                          : AW dispatcher back-pressure
//   outst_cnt_o, proto_err_o                : occupancy and sticky error
// Modports: master = dispatcher/bench side, slave = controller side.
interface dsp_w_order_ctrl_if #(
  parameter int SLV_ID_W = 1,
  parameter int OUTST_W  = 3
);
  logic                m_AWVALID_i;
  logic                m_AWREADY_i;
  logic [SLV_ID_W-1:0] m_AW_slv_id_i;
  logic                m_WVALID_i;
  logic                m_WREADY_i;
  logic                m_WLAST_i;
  logic [SLV_ID_W-1:0] dsp_AW_slv_id_o;
  logic                dsp_AW_disable_o;
  logic                dsp_AW_stall_o;
  logic [OUTST_W-1:0]  outst_cnt_o;
  logic                proto_err_o;

  modport master (
    output m_AWVALID_i, m_AWREADY_i, m_AW_slv_id_i,
    output m_WVALID_i, m_WREADY_i, m_WLAST_i,
    input  dsp_AW_slv_id_o, dsp_AW_disable_o, dsp_AW_stall_o,
    input  outst_cnt_o, proto_err_o
  );

  modport slave (
    input  m_AWVALID_i, m_AWREADY_i, m_AW_slv_id_i,
    input  m_WVALID_i, m_WREADY_i, m_WLAST_i,
    output dsp_AW_slv_id_o, dsp_AW_disable_o, dsp_AW_stall_o,
    output outst_cnt_o, proto_err_o
  );
endinterface

// File: rtl/dsp_w_order_ctrl.sv
// rtl/dsp_w_order_ctrl.sv - in-order AW slave-ID queue steering the W dispatcher
//
// Purpose: records the destination slave of each accepted AW and presents the
// oldest one to the W dispatcher until its WLAST handshake, so W bursts reach
// slaves in AW acceptance order. Stalls AW acceptance when the queue is full.
// Ports:
//   ACLK_i    : clock, rising edge
//   ARESETn_i : asynchronous active-low reset
//   bus       : dsp_w_order_ctrl_if.slave (AW/W observations in, steering out)
// All outputs come from registers only, so there is no input-to-output path
// that could close a loop through AWREADY or WREADY.
module dsp_w_order_ctrl #(
  parameter int SLV_AMT     = 2,
  parameter int SLV_ID_W    = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int OUTST_DEPTH = 4,
  parameter int OUTST_W     = $clog2(OUTST_DEPTH) + 1
) (
  input  logic              ACLK_i,
  input  logic              ARESETn_i,
  dsp_w_order_ctrl_if.slave bus
);
  localparam int PTR_W = OUTST_W - 1;

  typedef logic [SLV_ID_W-1:0] id_t;

  id_t              mem_q [OUTST_DEPTH];
  id_t              mem_d [OUTST_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUTST_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic push, pop, full, empty, push_ok, pop_ok;

  always_comb begin
    push  = bus.m_AWVALID_i & bus.m_AWREADY_i;
    pop   = bus.m_WVALID_i & bus.m_WREADY_i & bus.m_WLAST_i;
    full  = (cnt_q == OUTST_W'(OUTST_DEPTH));
    empty = (cnt_q == '0);
    pop_ok  = pop & ~empty;
    // A push into a full queue is fine when a pop frees the head slot in the
    // same cycle; otherwise it is dropped and flagged.
    push_ok = push & (~full | pop_ok);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (push & ~push_ok) | (pop & empty);
    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.m_AW_slv_id_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + OUTST_W'(1);
      2'b01:   cnt_d = cnt_q - OUTST_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < OUTST_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Head is forced to 0 when empty so stale memory never leaks out.
  assign bus.dsp_AW_slv_id_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.dsp_AW_disable_o = empty;
  assign bus.dsp_AW_stall_o   = full;
  assign bus.outst_cnt_o      = cnt_q;
  assign bus.proto_err_o      = err_q;
endmodule

// File: tb/tb_dsp_w_order_ctrl.sv
// tb/tb_dsp_w_order_ctrl.sv - self-checking bench for dsp_w_order_ctrl
module tb_dsp_w_order_ctrl;
  localparam int DEPTH = 4;
  localparam int IDW   = 1;
  localparam int CW    = 3;

  logic ACLK_i;
  logic ARESETn_i;

  dsp_w_order_ctrl_if #(.SLV_ID_W(IDW), .OUTST_W(CW)) bus ();

  dsp_w_order_ctrl #(
    .SLV_AMT(2), .SLV_ID_W(IDW), .OUTST_DEPTH(DEPTH), .OUTST_W(CW)
  ) dut (
    .ACLK_i(ACLK_i),
    .ARESETn_i(ARESETn_i),
    .bus(bus)
  );

  initial ACLK_i = 1'b0;
  always #5 ACLK_i = ~ACLK_i;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of slave IDs plus a sticky error flag.
  int mq[$];
  bit m_err;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    check({tag, "_cnt"},     int'(bus.outst_cnt_o),      sz);
    check({tag, "_disable"}, int'(bus.dsp_AW_disable_o), (sz == 0) ? 1 : 0);
    check({tag, "_stall"},   int'(bus.dsp_AW_stall_o),   (sz == DEPTH) ? 1 : 0);
    check({tag, "_id"},      int'(bus.dsp_AW_slv_id_o),  (sz == 0) ? 0 : mq[0]);
    check({tag, "_err"},     int'(bus.proto_err_o),      int'(m_err));
  endtask

  task automatic drive(input bit awv, input bit awr, input int id,
                       input bit wv, input bit wr, input bit wl);
    bus.m_AWVALID_i   = awv;
    bus.m_AWREADY_i   = awr;
    bus.m_AW_slv_id_i = id[IDW-1:0];
    bus.m_WVALID_i    = wv;
    bus.m_WREADY_i    = wr;
    bus.m_WLAST_i     = wl;
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare everything shortly after it.
  task automatic step(input string tag, input bit awv, input bit awr, input int id,
                      input bit wv, input bit wr, input bit wl);
    bit push, pop, pop_ok;
    int sz0;
    @(negedge ACLK_i);
    drive(awv, awr, id, wv, wr, wl);
    @(posedge ACLK_i);
    push   = awv & awr;
    pop    = wv & wr & wl;
    sz0    = mq.size();
    pop_ok = pop && (sz0 > 0);
    if (pop && sz0 == 0) m_err = 1'b1;
    if (pop_ok) void'(mq.pop_front());
    if (push) begin
      if (sz0 == DEPTH && !pop_ok) m_err = 1'b1;
      else mq.push_back(id % 2);
    end
    #1;
    check_model(tag);
  endtask

  task automatic push_id(input string tag, input int id);
    step(tag, 1, 1, id, 0, 0, 0);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge ACLK_i);
    drive(0, 0, 0, 0, 0, 0);
    ARESETn_i = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #2;
    check_model("rst");
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;
  endtask

  initial begin
    ARESETn_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_err = 1'b0;
    #2;
    ARESETn_i = 1'b0;
    #1;
    check_model("por");
    repeat (2) @(posedge ACLK_i);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;

    // Ordering: push 1,0,1 back-to-back, then three 2-beat bursts.
    push_id("ord_aw", 1);
    check("ord_first_visible", int'(bus.dsp_AW_disable_o), 0);
    push_id("ord_aw", 0);
    push_id("ord_aw", 1);
    for (int b = 0; b < 3; b++) begin
      step("ord_w0", 0, 0, 0, 1, 1, 0);
      step("ord_wl", 0, 0, 0, 1, 1, 1);
    end
    check("ord_disable_end", int'(bus.dsp_AW_disable_o), 1);

    // Full / stall / push-while-full.
    do_reset();
    push_id("full_aw", 1);
    push_id("full_aw", 0);
    push_id("full_aw", 1);
    push_id("full_aw", 1);
    check("full_cnt4", int'(bus.outst_cnt_o), 4);
    check("full_stall", int'(bus.dsp_AW_stall_o), 1);
    push_id("full_over", 0);
    check("over_err", int'(bus.proto_err_o), 1);
    check("over_head", int'(bus.dsp_AW_slv_id_o), 1);
    step("full_pop", 0, 0, 0, 1, 1, 1);
    check("pop_unstall", int'(bus.dsp_AW_stall_o), 0);

    // Push and pop together while full: legal, head advances.
    do_reset();
    push_id("sf_aw", 0);
    push_id("sf_aw", 1);
    push_id("sf_aw", 0);
    push_id("sf_aw", 0);
    step("sf_both", 1, 1, 1, 1, 1, 1);
    check("sf_cnt", int'(bus.outst_cnt_o), 4);
    check("sf_err", int'(bus.proto_err_o), 0);
    check("sf_head", int'(bus.dsp_AW_slv_id_o), 1);
    for (int k = 0; k < 4; k++) step("sf_drain", 0, 0, 0, 1, 1, 1);

    // Push and pop together with one entry: new ID becomes head.
    do_reset();
    push_id("s1_aw", 1);
    step("s1_both", 1, 1, 0, 1, 1, 1);
    check("s1_cnt", int'(bus.outst_cnt_o), 1);
    check("s1_head", int'(bus.dsp_AW_slv_id_o), 0);

    // Pointer wrap: 10 push/pop pairs.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push_id("wrap_aw", k % 2);
      check("wrap_head", int'(bus.dsp_AW_slv_id_o), k % 2);
      step("wrap_pop", 0, 0, 0, 1, 1, 1);
    end

    // Pop while empty.
    do_reset();
    step("epop", 0, 0, 0, 1, 1, 1);
    check("epop_err", int'(bus.proto_err_o), 1);
    check("epop_cnt", int'(bus.outst_cnt_o), 0);

    // Asynchronous reset mid-burst with three entries.
    do_reset();
    push_id("mb_aw", 1);
    push_id("mb_aw", 0);
    push_id("mb_aw", 1);
    step("mb_beat", 0, 0, 0, 1, 1, 0);
    @(negedge ACLK_i);
    #2;
    ARESETn_i = 1'b0;
    mq.delete();
    m_err = 1'b0;
    #1;
    check_model("mb_rst");
    @(negedge ACLK_i);
    drive(0, 0, 0, 0, 0, 0);
    ARESETn_i = 1'b1;
    idle("mb_idle");

    // Randomised traffic, mostly respecting stall but occasionally forcing it.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit awv, awr, wv, wr, wl;
      int id;
      awv = 1'($urandom_range(0, 1));
      awr = (mq.size() < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      id  = $urandom_range(0, 1);
      wv  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      wl  = ($urandom_range(0, 2) == 0);
      step("rnd", awv, awr, id, wv, wr, wl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
